// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: MEM/WB bundle field positions and register constants.
package mips_pkg;
  localparam int MEMWB_W        = 71;
  localparam int MEMWB_MEMTOREG = 70;
  localparam int MEMWB_ALU_HI   = 69;
  localparam int MEMWB_ALU_LO   = 38;
  localparam int MEMWB_REGWRITE = 37;
  localparam int MEMWB_WREG_HI  = 36;
  localparam int MEMWB_WREG_LO  = 32;
  localparam int MEMWB_RDATA_HI = 31;
  localparam int MEMWB_RDATA_LO = 0;
  localparam int REG_ZERO       = 0;
endpackage

// File: rtl/writeback_stage_reg_file.sv
// Architectural register file: two combinational read ports with write-first
// bypass, one write port, register 0 hardwired to zero.
module reg_file
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddrA,
  input  logic [AW-1:0] raddrB,
  output logic [DW-1:0] rdataA,
  output logic [DW-1:0] rdataB
);

  logic [DW-1:0] regs [NREGS];
  logic          wrEn;

  assign wrEn = we && (waddr != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[waddr] <= wdata;
    end
  end

  // Address zero wins over bypass so r0 reads zero regardless of the write port.
  always_comb begin
    rdataA = regs[raddrA];
    if (raddrA == AW'(REG_ZERO))            rdataA = '0;
    else if (wrEn && (raddrA == waddr))     rdataA = wdata;
  end

  always_comb begin
    rdataB = regs[raddrB];
    if (raddrB == AW'(REG_ZERO))            rdataB = '0;
    else if (wrEn && (raddrB == waddr))     rdataB = wdata;
  end

endmodule

// File: rtl/writeback_stage.sv
// MIPS write-back stage: result mux, commit strobe, register file and forwarding taps.
// Optional retire/commit counters are enabled with the WB_RETIRE_CNT_EN macro.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MEMWB_W-1:0] MEMWBReg,
  input  logic               wb_valid,
  input  logic [AW-1:0]      rd_addr_a,
  input  logic [AW-1:0]      rd_addr_b,
  output logic [DW-1:0]      rd_data_a,
  output logic [DW-1:0]      rd_data_b,
  output logic               wb_we,
  output logic [AW-1:0]      wb_reg,
  output logic [DW-1:0]      wb_data,
  output logic               wb_we_q,
  output logic [AW-1:0]      wb_reg_q,
  output logic [DW-1:0]      wb_data_q
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_cnt,
  output logic [31:0]        commit_cnt
`endif
);

  logic          memToReg;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] aluResult;
  logic [DW-1:0] memData;

  assign memToReg  = MEMWBReg[MEMWB_MEMTOREG];
  assign aluResult = MEMWBReg[MEMWB_ALU_HI:MEMWB_ALU_LO];
  assign regWrite  = MEMWBReg[MEMWB_REGWRITE];
  assign writeReg  = MEMWBReg[MEMWB_WREG_HI:MEMWB_WREG_LO];
  assign memData   = MEMWBReg[MEMWB_RDATA_HI:MEMWB_RDATA_LO];

  assign wb_data = memToReg ? memData : aluResult;
  assign wb_we   = wb_valid & regWrite & (writeReg != AW'(REG_ZERO));
  assign wb_reg  = wb_we ? writeReg : '0;

  reg_file #(.NREGS(NREGS), .DW(DW)) uRegFile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_we),
    .waddr  (wb_reg),
    .wdata  (wb_data),
    .raddrA (rd_addr_a),
    .raddrB (rd_addr_b),
    .rdataA (rd_data_a),
    .rdataB (rd_data_b)
  );

  // Bubbles load zeros so the 2-back forwarding tap never shows a stale destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q   <= wb_we;
      wb_reg_q  <= wb_we ? wb_reg  : '0;
      wb_data_q <= wb_we ? wb_data : '0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retireCnt;
  logic [31:0] commitCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retireCnt <= '0;
      commitCnt <= '0;
    end else begin
      if (wb_valid) retireCnt <= retireCnt + 32'd1;
      if (wb_we)    commitCnt <= commitCnt + 32'd1;
    end
  end

  assign retire_cnt = retireCnt;
  assign commit_cnt = commitCnt;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [70:0] MEMWBReg;
  logic        wb_valid;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_we_q;
  logic [4:0]  wb_reg_q;
  logic [31:0] wb_data_q;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt, commit_cnt;
`endif

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MEMWBReg  (MEMWBReg),
    .wb_valid  (wb_valid),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wb_we     (wb_we),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .wb_we_q   (wb_we_q),
    .wb_reg_q  (wb_reg_q),
    .wb_data_q (wb_data_q)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt),
    .commit_cnt(commit_cnt)
`endif
  );

  task automatic drive(input logic m2r, input logic [31:0] alu, input logic rw,
                       input logic [4:0] wreg, input logic [31:0] rdata, input logic valid);
    MEMWBReg = {m2r, alu, rw, wreg, rdata};
    wb_valid = valid;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  // One committing cycle: drive at negedge, leave it across the next posedge.
  task automatic commit(input logic [4:0] r, input logic [31:0] v);
    @(negedge clk);
    drive(1'b0, v, 1'b1, r, 32'h0, 1'b1);
    @(posedge clk); #1;
    bubble();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bubble();
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(i);
      #1;
      nChecks++;
      if (rd_data_a !== 32'h0) begin nFails++; $display("FAIL reset_rd_a[%0d] got %h want 0", i, rd_data_a); end
      nChecks++;
      if (rd_data_b !== 32'h0) begin nFails++; $display("FAIL reset_rd_b[%0d] got %h want 0", i, rd_data_b); end
    end
    nChecks++;
    if (wb_we_q !== 1'b0) begin nFails++; $display("FAIL reset_we_q got %b want 0", wb_we_q); end
    nChecks++;
    if (wb_reg_q !== 5'd0 || wb_data_q !== 32'h0) begin
      nFails++; $display("FAIL reset_q got reg %0d data %h want 0/0", wb_reg_q, wb_data_q);
    end
`ifdef WB_RETIRE_CNT_EN
    nChecks++;
    if (retire_cnt !== 32'd0 || commit_cnt !== 32'd0) begin
      nFails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", retire_cnt, commit_cnt);
    end
`endif
  endtask

  task automatic test_alu_commit();
    @(negedge clk);
    drive(1'b0, 32'h01010011, 1'b1, 5'd27, 32'hCAFEF00D, 1'b1);
    #1;
    nChecks++;
    if (wb_data !== 32'h01010011) begin nFails++; $display("FAIL alu_wb_data got %h want 01010011", wb_data); end
    nChecks++;
    if (wb_we !== 1'b1 || wb_reg !== 5'd27) begin
      nFails++; $display("FAIL alu_strobe got we %b reg %0d want 1/27", wb_we, wb_reg);
    end
    @(posedge clk); #1;
    bubble();
    rd_addr_a = 5'd27;
    #1;
    nChecks++;
    if (rd_data_a !== 32'h01010011) begin nFails++; $display("FAIL alu_stored got %h want 01010011", rd_data_a); end
    nChecks++;
    if (wb_reg_q !== 5'd27 || wb_we_q !== 1'b1 || wb_data_q !== 32'h01010011) begin
      nFails++; $display("FAIL alu_q got we %b reg %0d data %h want 1/27/01010011", wb_we_q, wb_reg_q, wb_data_q);
    end
  endtask

  task automatic test_load_bypass();
    @(negedge clk);
    drive(1'b1, 32'h12345678, 1'b1, 5'd24, 32'hDEADBEEF, 1'b1);
    rd_addr_a = 5'd24;
    rd_addr_b = 5'd24;
    #1;
    nChecks++;
    if (rd_data_b !== 32'hDEADBEEF) begin nFails++; $display("FAIL load_bypass_b got %h want deadbeef", rd_data_b); end
    nChecks++;
    if (rd_data_a !== 32'hDEADBEEF) begin nFails++; $display("FAIL load_bypass_a got %h want deadbeef", rd_data_a); end
    @(posedge clk); #1;
    bubble();
    #1;
    nChecks++;
    if (rd_data_b !== 32'hDEADBEEF) begin nFails++; $display("FAIL load_stored got %h want deadbeef", rd_data_b); end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    drive(1'b0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h0, 1'b1);
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    #1;
    nChecks++;
    if (wb_we !== 1'b0 || wb_reg !== 5'd0) begin
      nFails++; $display("FAIL r0_strobe got we %b reg %0d want 0/0", wb_we, wb_reg);
    end
    nChecks++;
    if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
      nFails++; $display("FAIL r0_bypass got %h/%h want 0/0", rd_data_a, rd_data_b);
    end
    @(posedge clk); #1;
    bubble();
    #1;
    nChecks++;
    if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
      nFails++; $display("FAIL r0_stored got %h/%h want 0/0", rd_data_a, rd_data_b);
    end
    nChecks++;
    if (wb_reg_q !== 5'd0 || wb_we_q !== 1'b0 || wb_data_q !== 32'h0) begin
      nFails++; $display("FAIL r0_q got we %b reg %0d data %h want 0/0/0", wb_we_q, wb_reg_q, wb_data_q);
    end
  endtask

  task automatic test_bubble();
    commit(5'd5, 32'h0000A5A5);
    @(negedge clk);
    drive(1'b0, 32'h00000005, 1'b1, 5'd5, 32'h0, 1'b0);
    rd_addr_a = 5'd5;
    #1;
    nChecks++;
    if (wb_we !== 1'b0) begin nFails++; $display("FAIL bubble_we got %b want 0", wb_we); end
    @(posedge clk); #1;
    bubble();
    #1;
    nChecks++;
    if (rd_data_a !== 32'h0000A5A5) begin nFails++; $display("FAIL bubble_stored got %h want 0000a5a5", rd_data_a); end
    nChecks++;
    if (wb_we_q !== 1'b0 || wb_reg_q !== 5'd0 || wb_data_q !== 32'h0) begin
      nFails++; $display("FAIL bubble_q got we %b reg %0d data %h want 0/0/0", wb_we_q, wb_reg_q, wb_data_q);
    end
`ifdef WB_RETIRE_CNT_EN
    // Valid cycles so far: alu, load, r0, reg5 write; commits exclude r0.
    nChecks++;
    if (retire_cnt !== 32'd4 || commit_cnt !== 32'd3) begin
      nFails++; $display("FAIL bubble_cnt got %0d/%0d want 4/3", retire_cnt, commit_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b0, 32'h00000111, 1'b1, 5'd9, 32'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h00000222, 1'b1, 5'd9, 32'h0, 1'b1);
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd9;
    #1;
    nChecks++;
    if (rd_data_a !== 32'h00000222 || rd_data_b !== 32'h00000222) begin
      nFails++; $display("FAIL b2b_bypass got %h/%h want 222/222", rd_data_a, rd_data_b);
    end
    nChecks++;
    if (wb_data_q !== 32'h00000111 || wb_reg_q !== 5'd9) begin
      nFails++; $display("FAIL b2b_q got reg %0d data %h want 9/111", wb_reg_q, wb_data_q);
    end
    @(posedge clk); #1;
    bubble();
    #1;
    nChecks++;
    if (rd_data_a !== 32'h00000222) begin nFails++; $display("FAIL b2b_stored got %h want 222", rd_data_a); end
  endtask

  task automatic test_x_memtoreg();
    commit(5'd7, 32'h00000077);
    @(negedge clk);
    drive(1'bx, 32'h0BADBAD0, 1'b1, 5'd7, 32'h0BADBAD1, 1'b0);
    rd_addr_a = 5'd7;
    #1;
    nChecks++;
    if (wb_we !== 1'b0) begin nFails++; $display("FAIL xm2r_we got %b want 0", wb_we); end
    @(posedge clk); #1;
    bubble();
    #1;
    nChecks++;
    if (rd_data_a !== 32'h00000077) begin nFails++; $display("FAIL xm2r_stored got %h want 77", rd_data_a); end
    nChecks++;
    if (wb_data_q !== 32'h0 || wb_reg_q !== 5'd0) begin
      nFails++; $display("FAIL xm2r_q got reg %0d data %h want 0/0", wb_reg_q, wb_data_q);
    end
  endtask

  task automatic test_midrun_reset();
    commit(5'd1, 32'h00000001);
    commit(5'd2, 32'h00000002);
    commit(5'd3, 32'h00000003);
    nChecks++;
    if (wb_reg_q !== 5'd3 || wb_data_q !== 32'h3) begin
      nFails++; $display("FAIL midrst_pre got reg %0d data %h want 3/3", wb_reg_q, wb_data_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (wb_we_q !== 1'b0 || wb_reg_q !== 5'd0 || wb_data_q !== 32'h0) begin
      nFails++; $display("FAIL midrst_q got we %b reg %0d data %h want 0/0/0", wb_we_q, wb_reg_q, wb_data_q);
    end
    for (int i = 1; i <= 3; i++) begin
      rd_addr_a = 5'(i);
      #1;
      nChecks++;
      if (rd_data_a !== 32'h0) begin nFails++; $display("FAIL midrst_reg[%0d] got %h want 0", i, rd_data_a); end
    end
    // A commit presented while reset is held must be discarded.
    @(negedge clk);
    drive(1'b0, 32'h00000044, 1'b1, 5'd4, 32'h0, 1'b1);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    rst_n = 1'b1;
    rd_addr_a = 5'd4;
    #1;
    nChecks++;
    if (rd_data_a !== 32'h0 || wb_we_q !== 1'b0) begin
      nFails++; $display("FAIL rst_commit got %h we_q %b want 0/0", rd_data_a, wb_we_q);
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_counter_wrap();
    nChecks++;
    if (retire_cnt !== 32'd0 || commit_cnt !== 32'd0) begin
      nFails++; $display("FAIL cnt_after_rst got %0d/%0d want 0/0", retire_cnt, commit_cnt);
    end
    @(negedge clk);
    force dut.commitCnt = 32'hFFFFFFFF;
    #1;
    release dut.commitCnt;
    commit(5'd10, 32'h0000000A);
    nChecks++;
    if (commit_cnt !== 32'd0) begin nFails++; $display("FAIL cnt_wrap got %h want 0", commit_cnt); end
    nChecks++;
    if (retire_cnt !== 32'd1) begin nFails++; $display("FAIL cnt_retire got %0d want 1", retire_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_commit();
    test_load_bypass();
    test_reg0();
    test_bubble();
    test_back_to_back();
    test_x_memtoreg();
    test_midrun_reset();
`ifdef WB_RETIRE_CNT_EN
    test_counter_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the MIPS core; consumes the 71-bit MEM/WB bundle that the memory stage produces.
- Selects the write-back value (memory data or ALU result) and commits it to the 32x32 architectural register file.
- Serves the decode stage's two read ports with write-first bypass.
- Exports the current and previous-cycle write-back destinations for forwarding.

Parameters:
- NREGS, 32, number of architectural registers; address width is log2(NREGS).
- DW, 32, data width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- MEMWBReg  input  71  bundle: [70] MemToReg, [69:38] ALU result, [37] RegWrite, [36:32] WriteRegister, [31:0] memory read data.
- wb_valid  input  1  bundle holds a real instruction; 0 = bubble.
- rd_addr_a  input  5  decode read port A address.
- rd_addr_b  input  5  decode read port B address.
- rd_data_a  output  32  port A data, combinational.
- rd_data_b  output  32  port B data, combinational.
- wb_we  output  1  write-back commit strobe this cycle, combinational.
- wb_reg  output  5  write-back destination this cycle.
- wb_data  output  32  write-back value this cycle.
- wb_we_q  output  1  registered copy of wb_we, for 2-back forwarding.
- wb_reg_q  output  5  registered copy of wb_reg.
- wb_data_q  output  32  registered copy of wb_data.

Behaviour:
- Write-back value: wb_data = MemToReg ? MEMWBReg[31:0] : MEMWBReg[69:38].
- Commit strobe: wb_we = wb_valid & RegWrite & (WriteRegister != 0).
- wb_reg = WriteRegister when wb_we = 1, otherwise 0.
- Register file:
  - Written on rising clk when wb_we = 1.
  - Register 0 is never written and always reads 0.
- Reads:
  - If rd_addr_x == wb_reg, wb_we = 1 and rd_addr_x != 0, rd_data_x = wb_data (same-cycle bypass).
  - Otherwise rd_data_x = stored register value.
  - Both ports may bypass in the same cycle.
- Registered outputs update every rising clk: wb_we_q <= wb_we; wb_reg_q <= wb_reg; wb_data_q <= wb_data.
  - When wb_we = 0, wb_reg_q and wb_data_q load 0, so bubbles never present a stale destination.
- Latency:
  - A committed value is visible through bypass in cycle N and through storage from cycle N+1.
  - The _q outputs reflect cycle N during cycle N+1.
- Reset (async assert, synchronous deassertion handled externally):
  - All 32 registers = 0.
  - wb_we_q = 0, wb_reg_q = 0, wb_data_q = 0.
  - Combinational outputs follow the inputs; a commit on the same edge reset is active is discarded.
- Boundary conditions:
  - Writing register 0 is a silent no-op: no bypass, wb_we = 0.
  - Back-to-back writes to the same register: last write wins.
  - A bubble (wb_valid = 0) with RegWrite = 1 does not commit.
  - X on the MemToReg field while wb_we = 0 must not propagate into the register file.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt, 32 bits: increments on every rising clk with wb_valid = 1, including stores and r0 writes.
  - Adds output commit_cnt, 32 bits: increments on wb_we = 1.
  - Both counters wrap modulo 2^32 and reset to 0.
- When undefined: neither port nor any counter logic exists.

Decomposition:
- Shared package mips_pkg:
  - Bit-position constants for the MEM/WB bundle fields: MEMWB_MEMTOREG = 70, MEMWB_ALU_HI/LO = 69/38, MEMWB_REGWRITE = 37, MEMWB_WREG_HI/LO = 36/32, MEMWB_RDATA_HI/LO = 31/0.
  - MEMWB_W = 71.
  - REG_ZERO = 0.
- One sub-module, reg_file: two read ports, one write port, r0 hardwired, write-first bypass. writeback_stage instantiates it and owns the mux, the strobe and the _q registers.

Test Plan:
- Reset check: hold rst_n = 0, then release; read all 32 registers on both ports -> every value is 0; wb_we_q = 0.
- ALU commit:
  - Stimulus: MemToReg = 0, ALU = 32'h01010011, RegWrite = 1, WriteRegister = 5'd27, wb_valid = 1.
  - Response: wb_data = 32'h01010011; after the edge, rd_addr_a = 27 returns 32'h01010011 and wb_reg_q = 27.
- Load commit with same-cycle bypass:
  - Stimulus: MemToReg = 1, rdData = 32'hDEADBEEF, WriteRegister = 24, rd_addr_b = 24 in the same cycle.
  - Response: rd_data_b = 32'hDEADBEEF before the edge.
- Register 0 protection: RegWrite = 1, WriteRegister = 0, ALU = 32'hFFFFFFFF -> wb_we = 0; register 0 reads 0 on both ports; wb_reg_q = 0.
- Bubble suppression: wb_valid = 0, RegWrite = 1, WriteRegister = 5, ALU = 32'h5 -> register 5 is unchanged and wb_we_q = 0. With WB_RETIRE_CNT_EN, neither counter increments.
- Mid-run reset and counter wrap:
  - Mid-run reset: write registers 1..3, assert rst_n asynchronously between edges -> registers and _q outputs clear immediately.
  - Counter wrap: with WB_RETIRE_CNT_EN, force commit_cnt to 32'hFFFFFFFF, then one commit -> commit_cnt = 0.
